// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), SLICE bits per clock, LSB slice first; optional LOGIC_ZERO_FLAG_EN adds 'zero'.
// Latency: accept at edge k -> out_valid from edge k+NSLICE; minimum issue interval NSLICE+2 cycles.
// Backpressure: in_ready only in IDLE; result/out_valid held in DONE until out_ready.
module sliced_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    generate
        if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
            $error("sliced_logic_unit: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] slice_res;

    // Constant part-selects per slice keep the mux free of variable-width index arithmetic.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        slice_res = '0;
        case (op_q)
            2'b00:   slice_res = a_sl & b_sl;
            2'b01:   slice_res = a_sl | b_sl;
            2'b10:   slice_res = a_sl ^ b_sl;
            default: slice_res = ~(a_sl | b_sl);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                for (int i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CW'(i)) begin
                        result_d[i*SLICE +: SLICE] = slice_res;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

`ifdef LOGIC_ZERO_FLAG_EN
    logic nonzero_q, nonzero_d;

    // Sticky: any written slice with a set bit marks the whole result nonzero.
    always_comb begin
        nonzero_d = nonzero_q;
        if ((state_q == IDLE) && in_valid) begin
            nonzero_d = 1'b0;
        end else if (state_q == BUSY) begin
            nonzero_d = nonzero_q | (|slice_res);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonzero_q <= 1'b0;
        end else begin
            nonzero_q <= nonzero_d;
        end
    end

    assign zero = (state_q == DONE) && !nonzero_q;
`endif

endmodule
